// File: rtl/rx_msg_parser.sv
// Tagged-field ASCII message parser: "{" field ("," field)* "}", field = 'A'-'Z' + NUM_DIGITS digits.
// Optional inter-byte timeout is compiled in when the RX_TIMEOUT_EN macro is defined.
module rx_msg_parser #(
  parameter int NUM_FIELDS     = 3,
  parameter int NUM_DIGITS     = 4,
  parameter int VAL_W          = 14,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        clk_enable,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_done,
  output logic [NUM_FIELDS*8-1:0]     field_tag,
  output logic [NUM_FIELDS*VAL_W-1:0] field_val,
  output logic                        msg_valid,
  output logic                        msg_error,
  output logic [1:0]                  err_code,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DIGIT, S_SEP} state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_FIELDS - 1);
  localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);

  if (NUM_FIELDS < 1 || NUM_FIELDS > 8 || NUM_DIGITS < 1 || NUM_DIGITS > 6 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("rx_msg_parser: parameter out of range");
  end

  state_t           state, state_d;
  logic [2:0]       idx, dcnt;
  logic [VAL_W-1:0] acc, acc_next;
  logic [7:0]       sh_tag [NUM_FIELDS];
  logic [VAL_W-1:0] sh_val [NUM_FIELDS];

  logic       byte_ok, timeout_hit;
  logic       is_lbrace, is_rbrace, is_comma, is_letter, is_digit;
  logic       ld_tag, dig_step, idx_clr, idx_inc, commit, err_set;
  logic [1:0] err_code_d;

  // Handshake: rx_done is a strobe with no back-pressure; a byte is consumed
  // on a rising edge where rx_done && clk_enable, otherwise it is lost.
  assign byte_ok   = rx_done && clk_enable;
  assign is_lbrace = (rx_data == 8'h7B);
  assign is_rbrace = (rx_data == 8'h7D);
  assign is_comma  = (rx_data == 8'h2C);
  assign is_letter = (rx_data >= 8'h41) && (rx_data <= 8'h5A);
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign acc_next  = (acc << 3) + (acc << 1) + VAL_W'(rx_data[3:0]);

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = clk_enable && !rx_done && (state != S_IDLE) &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (clk_enable) begin
      if (state == S_IDLE || rx_done || timeout_hit) to_cnt <= '0;
      else                                           to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)          state <= S_IDLE;
    else if (clk_enable) state <= state_d;
  end

  always_comb begin
    state_d    = state;
    ld_tag     = 1'b0;
    dig_step   = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    commit     = 1'b0;
    err_set    = 1'b0;
    err_code_d = 2'd0;
    if (timeout_hit) begin
      state_d    = S_IDLE;
      err_set    = 1'b1;
      err_code_d = 2'd2;
    end else if (byte_ok) begin
      if (is_lbrace) begin
        // '{' always restarts; mid-message it also reports the broken frame
        state_d = S_TAG;
        idx_clr = 1'b1;
        err_set = (state != S_IDLE);
      end else begin
        case (state)
          S_TAG: begin
            if (is_letter) begin
              ld_tag  = 1'b1;
              state_d = S_DIGIT;
            end else begin
              err_set = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_DIGIT: begin
            if (is_digit) begin
              dig_step = 1'b1;
              if (dcnt == LAST_DIG) state_d = S_SEP;
            end else begin
              err_set = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_SEP: begin
            state_d = S_IDLE;
            if (is_comma && idx != LAST_IDX) begin
              idx_inc = 1'b1;
              state_d = S_TAG;
            end else if (is_rbrace && idx == LAST_IDX) begin
              commit = 1'b1;
            end else if (is_comma || is_rbrace) begin
              err_set    = 1'b1;
              err_code_d = 2'd1;
            end else begin
              err_set = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      dcnt      <= '0;
      acc       <= '0;
      field_tag <= '0;
      field_val <= '0;
      msg_valid <= 1'b0;
      msg_error <= 1'b0;
      err_code  <= 2'd0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        sh_tag[i] <= '0;
        sh_val[i] <= '0;
      end
    end else if (clk_enable) begin
      msg_valid <= commit;
      msg_error <= err_set;
      if (err_set) err_code <= err_code_d;

      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 3'd1;

      if (ld_tag) begin
        acc  <= '0;
        dcnt <= '0;
      end else if (dig_step) begin
        acc  <= acc_next;
        dcnt <= dcnt + 3'd1;
      end

      // Shadow value tracks the running accumulator so it is final after the last digit
      for (int i = 0; i < NUM_FIELDS; i++) begin
        if (idx == 3'(i)) begin
          if (ld_tag)   sh_tag[i] <= rx_data;
          if (ld_tag)   sh_val[i] <= '0;
          if (dig_step) sh_val[i] <= acc_next;
        end
      end

      if (commit) begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          field_tag[i*8 +: 8]         <= sh_tag[i];
          field_val[i*VAL_W +: VAL_W] <= sh_val[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_msg_parser.sv
// Bench for rx_msg_parser: directed frames plus randomized message kinds built from
// field descriptions, with expected msg_valid/msg_error events queued for a monitor.
module tb_rx_msg_parser;

  localparam int NF = 3;
  localparam int ND = 4;
  localparam int VW = 14;
  localparam int TO = 50;
  localparam int TW = NF * 8;
  localparam int FW = NF * VW;
  localparam int W  = 3 + TW + FW;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clk_enable = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic [TW-1:0] field_tag;
  logic [FW-1:0] field_val;
  logic          msg_valid, msg_error, busy;
  logic [1:0]    err_code, dbg_state;

  rx_msg_parser #(
    .NUM_FIELDS(NF), .NUM_DIGITS(ND), .VAL_W(VW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .rx_data(rx_data), .rx_done(rx_done),
    .field_tag(field_tag), .field_val(field_val),
    .msg_valid(msg_valid), .msg_error(msg_error), .err_code(err_code),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  logic [W-1:0]  exp_q[$];
  logic [TW-1:0] m_tags;
  logic [FW-1:0] m_vals;
  logic [TW-1:0] g_tags;
  logic [FW-1:0] g_vals;
  logic [7:0]    msg_q[$];
  logic [7:0]    junk_t [6] = '{8'h2F, 8'h3A, 8'h40, 8'h5B, 8'h61, 8'h20};
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  task automatic push_err(input logic [1:0] code);
    exp_q.push_back({1'b1, code, m_tags, m_vals});
  endtask

  task automatic push_valid(input logic [TW-1:0] t, input logic [FW-1:0] v);
    m_tags = t;
    m_vals = v;
    exp_q.push_back({1'b0, 2'b00, t, v});
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Builds "{" + n fields (+ "}" when close) and records the decoded tags/values
  task automatic build_msg(input int n, input bit close);
    int val;
    logic [7:0] tag;
    msg_q.delete();
    g_tags = '0;
    g_vals = '0;
    msg_q.push_back(8'h7B);
    for (int i = 0; i < n; i++) begin
      if (i > 0) msg_q.push_back(8'h2C);
      tag = 8'h41 + 8'($urandom_range(0, 25));
      val = $urandom_range(0, pow10(ND) - 1);
      g_tags[i*8 +: 8]   = tag;
      g_vals[i*VW +: VW] = val[VW-1:0];
      msg_q.push_back(tag);
      for (int d = ND - 1; d >= 0; d--) msg_q.push_back(8'h30 + 8'((val / pow10(d)) % 10));
    end
    if (close) msg_q.push_back(8'h7D);
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data    = b;
    rx_done    = 1'b1;
    clk_enable = 1'b1;
    tick();
    rx_done = 1'b0;
    repeat ($urandom_range(0, gap)) begin
      clk_enable = 1'($urandom_range(0, 1));
      if (!clk_enable && $urandom_range(0, 3) == 0) begin
        rx_done = 1'b1;
        rx_data = 8'($urandom_range(0, 255));
      end
      tick();
      rx_done = 1'b0;
    end
    clk_enable = 1'b1;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic send_range(input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++) send_byte(msg_q[i], gap);
  endtask

  task automatic do_reset();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("rst_field_tag", W'(field_tag), W'(0));
    check("rst_field_val", W'(field_val), W'(0));
    check("rst_msg_valid", W'(msg_valid), W'(0));
    check("rst_msg_error", W'(msg_error), W'(0));
    check("rst_err_code", W'(err_code), W'(0));
    check("rst_busy", W'(busy), W'(0));
    m_tags = '0;
    m_vals = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic         prev_en;
    logic [W-1:0] act, e;
    prev_en = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (prev_en && rst_n && (msg_valid || msg_error)) begin
        check("pulse_overlap", W'(msg_valid & msg_error), W'(0));
        act = {msg_error, msg_error ? err_code : 2'b00, field_tag, field_val};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got %h, required no event", act);
        end else begin
          e = exp_q.pop_front();
          check("event", act, e);
        end
      end
      prev_en = clk_enable;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_tags = '0;
    m_vals = '0;
    do_reset();

    push_valid({8'h42, 8'h47, 8'h52}, {14'd89, 14'd567, 14'd1234});
    send_str("{R1234,G0567,B0089}", 0);
    repeat (2) tick();
    check("busy_after_msg", W'(busy), W'(0));

    push_err(2'd0);
    send_str("{R12a4", 0);
    repeat (2) tick();
    check("busy_after_syntax", W'(busy), W'(0));
    push_valid({8'h42, 8'h47, 8'h52}, {14'd3, 14'd2, 14'd1});
    send_str("{R0001,G0002,B0003}", 1);

    push_err(2'd1);
    send_str("{R1234,G0567}", 0);
    push_err(2'd1);
    send_str("{R1234,G0567,B0089,X12", 0);

    push_err(2'd0);
    push_valid({8'h42, 8'h47, 8'h52}, {14'd3, 14'd2, 14'd1});
    send_str("{R1234,G05{R0001,G0002,B0003}", 0);

    send_str("{R12", 0);
`ifdef RX_TIMEOUT_EN
    push_err(2'd2);
`endif
    repeat (TO + 10) tick();
`ifdef RX_TIMEOUT_EN
    check("busy_after_timeout", W'(busy), W'(0));
    send_str("{R12", 0);
`else
    check("busy_waiting", W'(busy), W'(1));
`endif
    do_reset();
    push_valid({8'h4D, 8'h5A, 8'h41}, {14'd42, 14'd9999, 14'd0});
    send_str("{A0000,Z9999,M0042}", 2);

    for (int it = 0; it < 200; it++) begin
      int kind, gap, k;
      logic [7:0] jb;
      kind = $urandom_range(0, 7);
      gap  = $urandom_range(0, 3);
      case (kind)
        0, 1, 2: begin
          build_msg(NF, 1'b1);
          push_valid(g_tags, g_vals);
          send_range(0, msg_q.size(), gap);
        end
        3: begin
          build_msg(NF, 1'b1);
          k = $urandom_range(1, msg_q.size() - 2);
          msg_q[k] = junk_t[$urandom_range(0, 5)];
          push_err(2'd0);
          send_range(0, k + 1, gap);
        end
        4: begin
          build_msg($urandom_range(1, NF - 1), 1'b1);
          push_err(2'd1);
          send_range(0, msg_q.size(), gap);
        end
        5: begin
          build_msg(NF, 1'b0);
          msg_q.push_back(8'h2C);
          push_err(2'd1);
          send_range(0, msg_q.size(), gap);
        end
        6: begin
          build_msg(NF, 1'b1);
          k = $urandom_range(1, msg_q.size() - 1);
          push_err(2'd0);
          send_range(0, k, gap);
          push_valid(g_tags, g_vals);
          send_range(0, msg_q.size(), gap);
        end
        default: begin
          repeat ($urandom_range(1, 4)) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'h7B) jb = 8'h00;
            send_byte(jb, gap);
          end
          build_msg(NF, 1'b1);
          k = $urandom_range(1, msg_q.size() - 1);
          send_range(0, k, gap);
          do_reset();
        end
      endcase
    end

    repeat (3) tick();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected events still pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_msg_parser.md
RX_MSG_PARSER -- requirements
Module: rx_msg_parser

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 3: number of tagged fields per message (1..8).
REQ-002 SHALL have parameter NUM_DIGITS, default 4: exact decimal digits per field (1..6).
REQ-003 SHALL have parameter VAL_W, default 14: width of each decoded field value.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000: inter-byte timeout in enabled cycles.
REQ-005 sys_clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clk_enable  input  1  qualifies every state, counter and output update.
REQ-008 rx_data  input  8  received byte, valid when rx_done=1.
REQ-009 rx_done  input  1  one-cycle byte strobe.
REQ-010 field_tag  output  NUM_FIELDS x 8  ASCII tag per field; index 0 = first received.
REQ-011 field_val  output  NUM_FIELDS x VAL_W  binary value per field.
REQ-012 msg_valid  output  1  one-cycle pulse: field_tag/field_val just updated.
REQ-013 msg_error  output  1  one-cycle pulse: message aborted.
REQ-014 err_code  output  2  abort cause, valid with msg_error: 0 syntax, 1 field count, 2 timeout, 3 never driven.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Message format SHALL be '{' (0x7B), NUM_FIELDS fields separated by ',' (0x2C), then '}' (0x7D); field = one tag 'A'-'Z' (0x41-0x5A) plus exactly NUM_DIGITS digits '0'-'9'.
REQ-017 States SHALL be IDLE, TAG, DIGIT, SEP; byte inputs are acted on only when rx_done=1 and clk_enable=1.
REQ-018 IDLE: '{' -> TAG, field index 0; any other byte ignored, no error.
REQ-019 TAG: letter stored to a shadow tag register, accumulator cleared, digit count 0 -> DIGIT; otherwise syntax error.
REQ-020 DIGIT: digit -> accumulator = accumulator*10 + (byte-0x30), truncated modulo 2^VAL_W; after NUM_DIGITS digits -> SEP; non-digit -> syntax error.
REQ-021 SEP: ',' with field index < NUM_FIELDS-1 -> TAG, index+1; '}' with index = NUM_FIELDS-1 -> complete; ',' at last field or '}' before last field -> field-count error (code 1); any other byte -> syntax error (code 0).
REQ-022 Completion SHALL copy all shadow tags/values into field_tag/field_val in one cycle and assert msg_valid on the cycle after the '}' strobe, then return to IDLE.
REQ-023 field_tag/field_val SHALL change only on completion; aborted messages leave them unchanged.
REQ-024 '{' received in TAG, DIGIT or SEP SHALL pulse msg_error with code 0, discard partial data, and enter TAG at field index 0 (resync) in the same cycle.
REQ-025 Any other abort SHALL pulse msg_error one cycle after the offending strobe and return to IDLE.
REQ-026 msg_valid and msg_error SHALL never be high together; both deassert after one enabled cycle.
REQ-027 rx_done while clk_enable=0 SHALL be ignored (byte lost).

Reset
REQ-028 rst_n low SHALL immediately force IDLE, clear shadow registers, counters, field_tag, field_val, msg_valid, msg_error, err_code, busy to 0.
REQ-029 Reset mid-message SHALL discard the message without error pulse after release.

Configuration
REQ-030 Macro RX_TIMEOUT_EN defined: counter of enabled cycles without rx_done while not IDLE; reaching TIMEOUT_CYCLES -> IDLE, msg_error, err_code=2; counter clears on each accepted byte and in IDLE.
REQ-031 RX_TIMEOUT_EN undefined: no timeout counter synthesised, code 2 never produced, parser waits indefinitely.

Verification
REQ-032 "{R1234,G0567,B0089}" -> one msg_valid; tags 0x52,0x47,0x42; values 1234,567,89; busy low after.
REQ-033 "{R12a4,..." -> msg_error code 0 after 'a'; prior field values unchanged; following "{R0001,G0002,B0003}" yields 1,2,3.
REQ-034 "{R1234,G0567}" -> msg_error code 1 at '}', no msg_valid; "{R1234,G0567,B0089,X..." -> code 1 at third ','.
REQ-035 "{R1234,G05{R0001,G0002,B0003}" -> msg_error code 0 at second '{', then msg_valid with 1,2,3.
REQ-036 RX_TIMEOUT_EN, TIMEOUT_CYCLES=50: "{R12" then 50 idle enabled cycles -> msg_error code 2, busy low; without macro, busy stays high.
REQ-037 rst_n pulsed after "{R12" -> all outputs 0, IDLE; next full message decodes correctly.
